// File: rtl/clk_en_pkg.sv
// Shared encodings for the clock-enable pattern generator: combiner modes and
// source-select FSM states.
package clk_en_pkg;

  typedef enum logic [1:0] {
    COMB_OR  = 2'd0,
    COMB_AND = 2'd1,
    COMB_XOR = 2'd2,
    COMB_OFF = 2'd3
  } comb_mode_e;

  typedef enum logic [1:0] {
    SEL_IDLE     = 2'd0,
    SEL_WAIT_OLD = 2'd1,
    SEL_WAIT_NEW = 2'd2
  } sel_state_e;

endpackage

// File: rtl/clk_en_div.sv
// One divider channel: free-running counter that pulses ch_en when cnt reaches div.
// A pending divide update is taken only at terminal count, so no period is truncated.
module clk_en_div #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_valid,
  input  logic [CNT_W-1:0] upd_div,
  output logic             ch_en,
  output logic             ch_phase,
  output logic             upd_done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic             tc;

  assign tc       = (cnt == div);
  // Gated so a DEF_DIV of 0 still gives a quiet ch_en while reset is held.
  assign ch_en    = tc & ~rst;
  assign upd_done = tc & upd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div      <= CNT_W'(DEF_DIV);
      ch_phase <= 1'b0;
    end else if (tc) begin
      cnt      <= '0;
      ch_phase <= ~ch_phase;
      if (upd_valid) div <= upd_div;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clk_en_pattern_gen.sv
// NCH programmable clock-enable channels with a shared config slot, a registered
// mask combiner and a glitch-free source-select FSM.
//   state        | meaning
//   SEL_IDLE     | sel_en follows sel_cur; accepts a switch request
//   SEL_WAIT_OLD | let one more pulse of the old source through
//   SEL_WAIT_NEW | sel_en held low until the target pulses, then switch
module clk_en_pattern_gen
  import clk_en_pkg::*;
#(
  parameter int  NCH     = 4,
  parameter int  CNT_W   = 8,
  parameter int  DEF_DIV = 1,
  localparam int CH_W    = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic [NCH-1:0]   ch_en,
  output logic [NCH-1:0]   ch_phase,
  input  logic [NCH-1:0]   comb_mask,
  input  logic [1:0]       comb_mode,
  output logic             comb_en,
  input  logic             sel_valid,
  input  logic [CH_W-1:0]  sel_ch,
  output logic             sel_busy,
  output logic [CH_W-1:0]  sel_cur,
  output logic             sel_en
);

  logic             pend;
  logic [CH_W-1:0]  pend_ch;
  logic [CNT_W-1:0] pend_div;
  logic [NCH-1:0]   upd_done;

  assign cfg_ready = ~pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= 1'b0;
      pend_ch  <= '0;
      pend_div <= '0;
    end else if (cfg_valid && !pend) begin
      pend     <= 1'b1;
      pend_ch  <= cfg_ch;
      pend_div <= cfg_div;
    end else if (|upd_done) begin
      pend <= 1'b0;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_en_div #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_div (
      .clk       (clk),
      .rst       (rst),
      .upd_valid (pend && (pend_ch == CH_W'(i))),
      .upd_div   (pend_div),
      .ch_en     (ch_en[i]),
      .ch_phase  (ch_phase[i]),
      .upd_done  (upd_done[i])
    );
  end

  logic [NCH-1:0] masked;
  logic           comb_nxt;

  always_comb begin
    masked   = ch_en & comb_mask;
    comb_nxt = 1'b0;
    case (comb_mode_e'(comb_mode))
      COMB_OR:  comb_nxt = |masked;
      COMB_AND: comb_nxt = (comb_mask != '0) && (masked == comb_mask);
      COMB_XOR: comb_nxt = ^masked;
      default:  comb_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) comb_en <= 1'b0;
    else     comb_en <= comb_nxt;
  end

  sel_state_e      state, state_nxt;
  logic [CH_W-1:0] target, target_nxt, cur_nxt;
  logic            sel_en_nxt;

  assign sel_busy = (state != SEL_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SEL_IDLE;
      target  <= '0;
      sel_cur <= '0;
      sel_en  <= 1'b0;
    end else begin
      state   <= state_nxt;
      target  <= target_nxt;
      sel_cur <= cur_nxt;
      sel_en  <= sel_en_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    cur_nxt    = sel_cur;
    sel_en_nxt = 1'b0;
    case (state)
      SEL_IDLE: begin
        sel_en_nxt = ch_en[sel_cur];
        if (sel_valid && (sel_ch != sel_cur)) begin
          target_nxt = sel_ch;
          state_nxt  = SEL_WAIT_OLD;
        end
      end
      SEL_WAIT_OLD: begin
        // A coincident target pulse is deliberately not consumed here.
        sel_en_nxt = ch_en[sel_cur];
        if (ch_en[sel_cur]) state_nxt = SEL_WAIT_NEW;
      end
      SEL_WAIT_NEW: begin
        sel_en_nxt = ch_en[target];
        if (ch_en[target]) begin
          cur_nxt   = target;
          state_nxt = SEL_IDLE;
        end
      end
      default: state_nxt = SEL_IDLE;
    endcase
  end

endmodule

// File: tb/tb_clk_en_pattern_gen.sv
// Bench for clk_en_pattern_gen: directed stimulus pushes cycle-stamped expectations
// into a scoreboard queue; a negedge monitor pops and compares them.
module tb_clk_en_pattern_gen;

  localparam int S_EN   = 0;
  localparam int S_PH   = 1;
  localparam int S_RDY  = 2;
  localparam int S_COMB = 3;
  localparam int S_SEL  = 4;
  localparam int S_BUSY = 5;
  localparam int S_CUR  = 6;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [3:0] ch_en;
  logic [3:0] ch_phase;
  logic [3:0] comb_mask;
  logic [1:0] comb_mode;
  logic       comb_en;
  logic       sel_valid;
  logic [1:0] sel_ch;
  logic       sel_busy;
  logic [1:0] sel_cur;
  logic       sel_en;

  clk_en_pattern_gen #(.NCH(4), .CNT_W(8), .DEF_DIV(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .ch_en     (ch_en),
    .ch_phase  (ch_phase),
    .comb_mask (comb_mask),
    .comb_mode (comb_mode),
    .comb_en   (comb_en),
    .sel_valid (sel_valid),
    .sel_ch    (sel_ch),
    .sel_busy  (sel_busy),
    .sel_cur   (sel_cur),
    .sel_en    (sel_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void expect_at(int c, int sig, logic [31:0] v, string nm);
    exp_t e;
    e.cyc = c; e.sig = sig; e.val = v; e.nm = nm;
    sb.push_back(e);
  endfunction

  function automatic logic [31:0] sample(int sig);
    case (sig)
      S_EN:    return {28'd0, ch_en};
      S_PH:    return {28'd0, ch_phase};
      S_RDY:   return {31'd0, cfg_ready};
      S_COMB:  return {31'd0, comb_en};
      S_SEL:   return {31'd0, sel_en};
      S_BUSY:  return {31'd0, sel_busy};
      default: return {30'd0, sel_cur};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = sample(sb[i].sig);
        total++;
        if (act !== sb[i].val) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%0h want=%0h", sb[i].nm, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s cyc=%0d not sampled (now %0d)", sb[i].nm, sb[i].cyc, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(output int base);
    rst = 1'b1;
    expect_at(cyc, S_EN,   0, "rst ch_en");
    expect_at(cyc, S_PH,   0, "rst ch_phase");
    expect_at(cyc, S_RDY,  1, "rst cfg_ready");
    expect_at(cyc, S_COMB, 0, "rst comb_en");
    expect_at(cyc, S_SEL,  0, "rst sel_en");
    expect_at(cyc, S_BUSY, 0, "rst sel_busy");
    expect_at(cyc, S_CUR,  0, "rst sel_cur");
    step(2);
    rst  = 1'b0;
    base = cyc;
  endtask

  task automatic cfg_pulse(logic [1:0] ch, logic [7:0] dv);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = dv;
    step(1);
    cfg_valid = 1'b0;
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int b;
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    comb_mask = '0; comb_mode = 2'd3; sel_valid = 1'b0; sel_ch = '0;
    step(1);

    // T1: reset values, first pulse one cycle after release, mid-run reset
    do_reset(b);
    expect_at(b + 1, S_EN,  'hF, "t1 first ch_en");
    expect_at(b + 2, S_EN,  0,   "t1 ch_en gap");
    expect_at(b + 2, S_PH,  'hF, "t1 phase toggled");
    expect_at(b + 2, S_SEL, 1,   "t1 sel_en ch0");
    expect_at(b + 3, S_EN,  'hF, "t1 second ch_en");
    expect_at(b + 4, S_PH,  0,   "t1 phase back");
    step(6);
    do_reset(b);

    // T2: ch2 div 1->3 applied at terminal count; second cfg while busy dropped
    expect_at(b + 1,  S_RDY, 1,        "t2 ready before");
    expect_at(b + 2,  S_RDY, 0,        "t2 ready low");
    expect_at(b + 3,  S_RDY, 0,        "t2 ready still low");
    expect_at(b + 4,  S_RDY, 1,        "t2 ready back");
    expect_at(b + 5,  S_RDY, 1,        "t2 busy cfg dropped");
    expect_at(b + 5,  S_EN,  'b1011,   "t2 ch2 skips");
    expect_at(b + 6,  S_EN,  0,        "t2 ch1 kept div");
    expect_at(b + 7,  S_EN,  'b1111,   "t2 ch2 pulse");
    expect_at(b + 9,  S_EN,  'b1011,   "t2 ch2 gap");
    expect_at(b + 11, S_EN,  'b1111,   "t2 ch2 period4");
    expect_at(b + 15, S_EN,  'b1111,   "t2 ch2 period4b");
    expect_at(b + 8,  S_PH,  'b0100,   "t2 phase a");
    expect_at(b + 10, S_PH,  'b1111,   "t2 phase b");
    expect_at(b + 12, S_PH,  'b0000,   "t2 phase c");
    expect_at(b + 16, S_PH,  'b0100,   "t2 phase period8");
    step(1);
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3;
    step(1);
    cfg_ch = 2'd1; cfg_div = 8'd0;
    step(1);
    cfg_valid = 1'b0;
    step(14);
    do_reset(b);

    // T3: div=0 continuous on ch0, div=255 period 256 on ch3
    expect_at(b + 1,   S_RDY, 0,       "t3 ready low a");
    expect_at(b + 2,   S_RDY, 1,       "t3 ready back a");
    expect_at(b + 3,   S_RDY, 0,       "t3 ready low b");
    expect_at(b + 4,   S_RDY, 1,       "t3 ready back b");
    expect_at(b + 2,   S_EN,  'b0001,  "t3 div0 a");
    expect_at(b + 3,   S_EN,  'b1111,  "t3 div0 b");
    expect_at(b + 4,   S_EN,  'b0001,  "t3 div0 c");
    expect_at(b + 5,   S_EN,  'b0111,  "t3 ch3 quiet");
    expect_at(b + 258, S_EN,  'b0001,  "t3 ch3 before tc");
    expect_at(b + 259, S_EN,  'b1111,  "t3 ch3 tc1");
    expect_at(b + 514, S_EN,  'b0001,  "t3 ch3 before tc2");
    expect_at(b + 515, S_EN,  'b1111,  "t3 ch3 tc2");
    cfg_pulse(2'd0, 8'd0);
    cfg_pulse(2'd3, 8'd255);
    step(513);
    do_reset(b);

    // T4: div {1,3,0,7}; combiner modes over masks 0011, 0000, 0100
    expect_at(b + 13, S_EN, 'b1111, "t4 all pulse");
    expect_at(b + 14, S_EN, 'b0100, "t4 only ch2");
    expect_at(b + 15, S_EN, 'b0101, "t4 ch0 ch2");
    expect_at(b + 17, S_EN, 'b0111, "t4 ch3 quiet");
    expect_at(b + 21, S_EN, 'b1111, "t4 ch3 period8");
    expect_at(b + 11, S_COMB, 0, "t4 or idle");
    expect_at(b + 12, S_COMB, 1, "t4 or one");
    expect_at(b + 13, S_COMB, 0, "t4 or none");
    expect_at(b + 14, S_COMB, 1, "t4 or both");
    expect_at(b + 15, S_COMB, 0, "t4 and none");
    expect_at(b + 16, S_COMB, 0, "t4 and one");
    expect_at(b + 17, S_COMB, 0, "t4 and idle");
    expect_at(b + 18, S_COMB, 1, "t4 and both");
    expect_at(b + 19, S_COMB, 0, "t4 xor none");
    expect_at(b + 20, S_COMB, 1, "t4 xor one");
    expect_at(b + 21, S_COMB, 0, "t4 xor idle");
    expect_at(b + 22, S_COMB, 0, "t4 xor both");
    expect_at(b + 24, S_COMB, 0, "t4 off one");
    expect_at(b + 26, S_COMB, 0, "t4 off both");
    expect_at(b + 28, S_COMB, 0, "t4 and mask0 a");
    expect_at(b + 30, S_COMB, 0, "t4 and mask0 b");
    expect_at(b + 31, S_COMB, 1, "t4 or ch2 a");
    expect_at(b + 32, S_COMB, 1, "t4 or ch2 b");

    // T5: select 0 -> 3
    for (int c = 34; c <= 54; c++)
      expect_at(b + c, S_SEL, 32'(c == 34 || c == 36 || c == 38 || c == 46 || c == 54), "t5 sel_en");
    expect_at(b + 34, S_BUSY, 0, "t5 busy before");
    expect_at(b + 35, S_BUSY, 1, "t5 busy old");
    expect_at(b + 36, S_BUSY, 1, "t5 busy new");
    expect_at(b + 37, S_BUSY, 1, "t5 busy new b");
    expect_at(b + 38, S_BUSY, 0, "t5 busy done");
    expect_at(b + 40, S_BUSY, 0, "t5 req ignored busy");
    expect_at(b + 37, S_CUR,  0, "t5 cur old");
    expect_at(b + 38, S_CUR,  3, "t5 cur new");
    expect_at(b + 40, S_CUR,  3, "t5 cur stays");

    // T6: same-channel request, coincident pulses on 3 -> 1, reset in WAIT_NEW
    for (int c = 55; c <= 74; c++)
      expect_at(b + c, S_SEL, 32'(c == 62 || c == 66 || c == 70 || c == 74), "t6 sel_en");
    expect_at(b + 57, S_BUSY, 0, "t6 same ch no busy");
    expect_at(b + 58, S_BUSY, 1, "t6 busy old");
    expect_at(b + 61, S_BUSY, 1, "t6 busy old b");
    expect_at(b + 64, S_BUSY, 1, "t6 busy new");
    expect_at(b + 66, S_BUSY, 0, "t6 busy done");
    expect_at(b + 64, S_CUR,  3, "t6 cur held");
    expect_at(b + 66, S_CUR,  1, "t6 cur new");
    expect_at(b + 79, S_BUSY, 1, "t6 busy wait_new");
    expect_at(b + 79, S_CUR,  1, "t6 cur before rst");

    cfg_pulse(2'd1, 8'd3);
    cfg_pulse(2'd2, 8'd0);
    cfg_pulse(2'd3, 8'd7);
    step(4);
    comb_mode = 2'd0; comb_mask = 4'b0011;
    step(4);
    comb_mode = 2'd1;
    step(4);
    comb_mode = 2'd2;
    step(4);
    comb_mode = 2'd3;
    step(4);
    comb_mode = 2'd1; comb_mask = 4'b0000;
    step(4);
    comb_mode = 2'd0; comb_mask = 4'b0100;
    step(4);
    sel_valid = 1'b1; sel_ch = 2'd3;
    step(1);
    sel_ch = 2'd1;
    step(2);
    sel_valid = 1'b0;
    step(19);
    sel_valid = 1'b1; sel_ch = 2'd3;
    step(1);
    sel_ch = 2'd1;
    step(1);
    sel_valid = 1'b0;
    step(18);
    sel_valid = 1'b1; sel_ch = 2'd3;
    step(1);
    sel_valid = 1'b0;
    step(3);
    do_reset(b);
    expect_at(b + 1, S_CUR,  0,   "t6 cur after rst");
    expect_at(b + 1, S_BUSY, 0,   "t6 busy after rst");
    expect_at(b + 1, S_EN,   'hF, "t6 ch_en after rst");
    expect_at(b + 2, S_SEL,  1,   "t6 sel_en ch0");
    step(4);

    foreach (sb[i]) begin
      total++;
      bad++;
      $display("FAIL %s cyc=%0d never reached", sb[i].nm, sb[i].cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
